// File: rtl/rot_arbiter_if.sv
// ============================================================================
//  Module   : rot_arbiter_if
//  Brief    : Requester and result-side signal bundle for rot_arbiter.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface rot_arbiter_if #(
    parameter int NREQ = 4
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_data;
    logic [3*NREQ-1:0] req_amt;
    logic [NREQ-1:0]   req_left;
    logic              out_valid;
    logic              out_ready;
    logic [7:0]        out_data;
    logic [IDW-1:0]    out_id;
    logic [15:0]       done_cnt;

    // master: requesters plus the downstream consumer
    modport master (
        output req_valid, req_data, req_amt, req_left, out_ready,
        input  req_ready, out_valid, out_data, out_id, done_cnt
    );

    modport slave (
        input  req_valid, req_data, req_amt, req_left, out_ready,
        output req_ready, out_valid, out_data, out_id, done_cnt
    );
endinterface

`default_nettype wire

// File: rtl/rot_arbiter.sv
// ============================================================================
//  Module   : rot_arbiter
//  Brief    : Round-robin arbiter sharing one 8-bit rotate-right unit among
//             NREQ requesters, with a single-entry registered output stage.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_shifter (
    input  logic [7:0] a,
    input  logic [2:0] s,
    output logic [7:0] y
);
    logic [15:0] w_dbl;

    // Low byte of the doubled word shifted right is a rotate right.
    assign w_dbl = {a, a} >> s;
    assign y     = w_dbl[7:0];
endmodule

module rot_arbiter #(
    parameter int NREQ = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    rot_arbiter_if.slave bus
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [0:0] {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    state_t         r_state;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_id;
    logic [7:0]     r_data;
    logic [15:0]    r_done_cnt;

    logic [7:0]     w_req_data [NREQ];
    logic [2:0]     w_req_amt  [NREQ];
    logic [IDW:0]   w_sum;
    logic [IDW-1:0] w_idx;
    logic [IDW-1:0] w_win;
    logic           w_found;
    logic           w_can_accept;
    logic           w_accept;
    logic [7:0]     w_sel_data;
    logic [2:0]     w_sel_amt;
    logic           w_sel_left;
    logic [2:0]     w_shamt;
    logic [7:0]     w_rot;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_data[gi] = bus.req_data[8*gi +: 8];
            assign w_req_amt[gi]  = bus.req_amt[3*gi +: 3];
        end
    endgenerate

    // Search from r_ptr upward, wrapping at NREQ (NREQ need not be a power of 2).
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_sum   = '0;
        w_idx   = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NREQ)) begin
                w_sum = w_sum - (IDW+1)'(NREQ);
            end
            w_idx = w_sum[IDW-1:0];
            if (!w_found && bus.req_valid[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_can_accept  = (r_state == EMPTY) | bus.out_ready;
    assign w_accept      = w_found & w_can_accept & rst_n;
    assign bus.req_ready = w_accept ? (NREQ'(1) << w_win) : '0;

    assign w_sel_data = w_req_data[w_win];
    assign w_sel_amt  = w_req_amt[w_win];
    assign w_sel_left = bus.req_left[w_win];
    // Left by n equals right by (8 - n) mod 8; 3-bit wrap maps left 0 to 0.
    assign w_shamt    = w_sel_left ? (3'd0 - w_sel_amt) : w_sel_amt;

    barrel_shifter u_rot (
        .a (w_sel_data),
        .s (w_shamt),
        .y (w_rot)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_data     <= 8'h00;
            r_id       <= '0;
            r_ptr      <= '0;
            r_done_cnt <= 16'h0000;
        end else begin
            if (r_state == FULL && bus.out_ready) begin
                r_done_cnt <= r_done_cnt + 16'd1;
            end
            if (w_accept) begin
                r_data  <= w_rot;
                r_id    <= w_win;
                r_ptr   <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + IDW'(1);
                r_state <= FULL;
            end else if (bus.out_ready) begin
                r_state <= EMPTY;
            end
        end
    end

    assign bus.out_valid = (r_state == FULL);
    assign bus.out_data  = r_data;
    assign bus.out_id    = r_id;
    assign bus.done_cnt  = r_done_cnt;

endmodule

`default_nettype wire

// File: tb/tb_rot_arbiter.sv
// ============================================================================
//  Module   : tb_rot_arbiter
//  Brief    : Scoreboard bench for rot_arbiter with a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_rot_arbiter;
    localparam int NREQ = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rot_arbiter_if #(.NREQ(NREQ)) bus ();

    rot_arbiter #(.NREQ(NREQ)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] data;
        int         id;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Model state: next search start, output-register occupancy, handshakes.
    int   m_ptr;
    bit   m_full;
    int   m_cnt;

    function automatic logic [7:0] rot_ref(logic [7:0] d, int a, bit left);
        int v;
        int r;
        v = d;
        if (left) r = (v << a) | (v >> (8 - a));
        else      r = (v >> a) | (v << (8 - a));
        return 8'(r & 255);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ptr  = 0;
        m_full = 1'b0;
        m_cnt  = 0;
    endtask

    task automatic set_req(int i, logic [7:0] d, logic [2:0] a, bit left);
        bus.req_data[8*i +: 8] = d;
        bus.req_amt[3*i +: 3]  = a;
        bus.req_left[i]        = left;
    endtask

    // One clock: compare handshake outputs against the model, then advance it.
    task automatic step();
        int         win;
        bit         can;
        logic [3:0] exp_rdy;
        @(negedge clk);
        can = !m_full || bus.out_ready;
        win = -1;
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_ptr + k) % NREQ;
            if (win < 0 && bus.req_valid[idx]) win = idx;
        end
        exp_rdy = (can && win >= 0) ? 4'(1 << win) : 4'b0000;
        check("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
        check("out_valid", 32'(bus.out_valid), 32'(m_full));
        check("done_cnt",  32'(bus.done_cnt),  32'(m_cnt));
        if (m_full && bus.out_ready) m_cnt = (m_cnt + 1) % 65536;
        if (exp_rdy != 4'b0000) begin
            sb_q.push_back('{data: rot_ref(bus.req_data[8*win +: 8],
                                           int'(bus.req_amt[3*win +: 3]),
                                           bus.req_left[win]),
                             id: win});
            m_ptr  = (win + 1) % NREQ;
            m_full = 1'b1;
        end else if (bus.out_ready) begin
            m_full = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Monitor: every completed output handshake is matched against the queue.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_output: got data 0x%0h id %0d, expected none",
                             bus.out_data, bus.out_id);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_data", 32'(bus.out_data), 32'(e.data));
                    check("out_id",   32'(bus.out_id),   32'(e.id));
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 1ms");
        $fatal(1, "watchdog");
    end

    int seq [6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_amt   = '0;
        bus.req_left  = '0;
        bus.out_ready = 1'b1;
        model_reset();
        #1;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_out_valid", 32'(bus.out_valid), 32'h0);
        check("rst_out_data",  32'(bus.out_data),  32'h0);
        check("rst_done_cnt",  32'(bus.done_cnt),  32'h0);
        do_reset();

        // Right rotates on requester 0
        set_req(0, 8'h81, 3'd1, 1'b0); bus.req_valid = 4'b0001; step(); bus.req_valid = '0;
        check("r0_81_1_data", 32'(bus.out_data), 32'hC0);
        check("r0_81_1_id",   32'(bus.out_id),   32'd0);
        set_req(0, 8'h81, 3'd0, 1'b0); bus.req_valid = 4'b0001; step(); bus.req_valid = '0;
        check("r0_81_0_data", 32'(bus.out_data), 32'h81);
        set_req(0, 8'h01, 3'd7, 1'b0); bus.req_valid = 4'b0001; step(); bus.req_valid = '0;
        check("r0_01_7_data", 32'(bus.out_data), 32'h02);

        // Left rotates on requester 2
        set_req(2, 8'h81, 3'd1, 1'b1); bus.req_valid = 4'b0100; step(); bus.req_valid = '0;
        check("l2_81_1_data", 32'(bus.out_data), 32'h03);
        check("l2_81_1_id",   32'(bus.out_id),   32'd2);
        set_req(2, 8'hF0, 3'd4, 1'b1); bus.req_valid = 4'b0100; step(); bus.req_valid = '0;
        check("l2_F0_4_data", 32'(bus.out_data), 32'h0F);
        set_req(2, 8'h5A, 3'd0, 1'b1); bus.req_valid = 4'b0100; step(); bus.req_valid = '0;
        check("l2_5A_0_data", 32'(bus.out_data), 32'h5A);
        step();

        // Fairness from a freshly reset pointer
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h11 * (i + 1)), 3'(i), 1'b0);
        bus.req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            step();
            check("fair_id",  32'(bus.out_id),   32'(seq[i]));
            check("fair_cnt", 32'(bus.done_cnt), 32'(i));
        end

        // Backpressure: hold a result from requester 1
        set_req(1, 8'h3C, 3'd2, 1'b0);
        bus.req_valid = 4'b0010;
        step();
        bus.req_valid = 4'b1111;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_valid", 32'(bus.out_valid), 32'h1);
            check("bp_data",  32'(bus.out_data),  32'h0F);
            check("bp_id",    32'(bus.out_id),    32'd1);
            check("bp_ready", 32'(bus.req_ready), 32'h0);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_grant", 32'(bus.req_ready), 32'b0100);
        step();

        // Reset while FULL
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(bus.out_valid), 32'h0);
        check("mid_rst_cnt",   32'(bus.done_cnt),  32'h0);
        check("mid_rst_data",  32'(bus.out_data),  32'h0);
        check("mid_rst_ready", 32'(bus.req_ready), 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        bus.req_valid = 4'b1001;
        rst_n = 1'b1;
        #1;
        check("post_rst_grant", 32'(bus.req_ready), 32'b0001);
        step();
        check("post_rst_id", 32'(bus.out_id), 32'd0);

        // Randomised traffic
        for (int n = 0; n < 600; n++) begin
            for (int i = 0; i < NREQ; i++) set_req(i, 8'($urandom), 3'($urandom), 1'($urandom));
            bus.req_valid = 4'($urandom);
            bus.out_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        // Counter wrap under full throughput
        bus.out_ready = 1'b1;
        bus.req_valid = 4'b1111;
        while (m_cnt != 65535) step();
        check("cnt_ffff", 32'(bus.done_cnt), 32'hFFFF);
        step();
        check("cnt_wrap", 32'(bus.done_cnt), 32'h0000);

        bus.req_valid = '0;
        step();
        step();
        check("drain", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
